// File: rtl/ttt_board_judge_if.sv
// Handshake and result bundle between game control and the board judge.
interface ttt_board_judge_if;
    logic       start;
    logic [8:0] cell_valid;
    logic [8:0] cell_symbol;
    logic       busy;
    logic       done;
    logic       win;
    logic       winner_symbol;
    logic [2:0] win_line;
    logic       multi_win;
    logic       draw;

    // Game control side: issues requests, consumes results.
    modport master (
        output start, cell_valid, cell_symbol,
        input  busy, done, win, winner_symbol, win_line, multi_win, draw
    );

    // Judge side: samples the board, produces results.
    modport slave (
        input  start, cell_valid, cell_symbol,
        output busy, done, win, winner_symbol, win_line, multi_win, draw
    );
endinterface

// File: rtl/ttt_board_judge.sv
// Tic-tac-toe board judge: snapshots the nine cells on start, scans the eight
// winning lines one per clock, then reports win/draw with a one-cycle done.
module ttt_board_judge #(
    parameter bit SCAN_ALL = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    ttt_board_judge_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t     state, state_nx;
    logic [8:0] snap_v, snap_s;
    logic [2:0] line_idx;
    logic       acc_found, acc_sym, acc_multi;
    logic [2:0] acc_line;
    logic [3:0] ca, cb, cc;
    logic       line_hit;
    logic       scan_last;

    // Cell indices of the line currently under evaluation.
    always_comb begin
        ca = 4'd0;
        cb = 4'd0;
        cc = 4'd0;
        case (line_idx)
            3'd0: begin ca = 4'd0; cb = 4'd1; cc = 4'd2; end
            3'd1: begin ca = 4'd3; cb = 4'd4; cc = 4'd5; end
            3'd2: begin ca = 4'd6; cb = 4'd7; cc = 4'd8; end
            3'd3: begin ca = 4'd0; cb = 4'd3; cc = 4'd6; end
            3'd4: begin ca = 4'd1; cb = 4'd4; cc = 4'd7; end
            3'd5: begin ca = 4'd2; cb = 4'd5; cc = 4'd8; end
            3'd6: begin ca = 4'd0; cb = 4'd4; cc = 4'd8; end
            3'd7: begin ca = 4'd2; cb = 4'd4; cc = 4'd6; end
            default: begin ca = 4'd0; cb = 4'd0; cc = 4'd0; end
        endcase
    end

    // A line wins when all three cells are occupied by the same symbol.
    assign line_hit = snap_v[ca] & snap_v[cb] & snap_v[cc] &
                      (snap_s[ca] == snap_s[cb]) & (snap_s[cb] == snap_s[cc]);

    // Scan ends after line 7, or at the first win when early exit is allowed.
    assign scan_last = (line_idx == 3'd7) || (!SCAN_ALL && line_hit);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SCAN;
            SCAN:    if (scan_last) state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Snapshot, line accumulators and registered result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_v            <= '0;
            snap_s            <= '0;
            line_idx          <= '0;
            acc_found         <= 1'b0;
            acc_sym           <= 1'b0;
            acc_line          <= '0;
            acc_multi         <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.win           <= 1'b0;
            bus.winner_symbol <= 1'b0;
            bus.win_line      <= '0;
            bus.multi_win     <= 1'b0;
            bus.draw          <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        snap_v    <= bus.cell_valid;
                        snap_s    <= bus.cell_symbol;
                        line_idx  <= '0;
                        acc_found <= 1'b0;
                        acc_sym   <= 1'b0;
                        acc_line  <= '0;
                        acc_multi <= 1'b0;
                        bus.busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    line_idx <= line_idx + 3'd1;
                    if (line_hit) begin
                        if (!acc_found) begin
                            acc_found <= 1'b1;
                            acc_sym   <= snap_s[ca];
                            acc_line  <= line_idx;
                        end else if (SCAN_ALL) begin
                            acc_multi <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    bus.win           <= acc_found;
                    bus.winner_symbol <= acc_sym;
                    bus.win_line      <= acc_line;
                    bus.multi_win     <= acc_multi;
                    bus.draw          <= !acc_found && (snap_v == 9'h1FF);
                    bus.done          <= 1'b1;
                    bus.busy          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_board_judge.sv
// Bench for ttt_board_judge: one instance per SCAN_ALL setting driven by the
// same stimulus, each checked every cycle against a rule-level game model.
module tb_ttt_board_judge;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [8:0] cv, cs;

    always #5 clk = ~clk;

    ttt_board_judge_if j0 ();
    ttt_board_judge_if j1 ();

    assign j0.start = start;  assign j0.cell_valid = cv;  assign j0.cell_symbol = cs;
    assign j1.start = start;  assign j1.cell_valid = cv;  assign j1.cell_symbol = cs;

    ttt_board_judge #(.SCAN_ALL(1'b0)) u0 (.clk(clk), .reset_n(reset_n), .bus(j0));
    ttt_board_judge #(.SCAN_ALL(1'b1)) u1 (.clk(clk), .reset_n(reset_n), .bus(j1));

    // Index p: 0 = SCAN_ALL=0 instance, 1 = SCAN_ALL=1 instance.
    logic       o_busy[2], o_done[2], o_win[2], o_sym[2], o_multi[2], o_draw[2];
    logic [2:0] o_line[2];
    assign o_busy[0] = j0.busy;  assign o_busy[1] = j1.busy;
    assign o_done[0] = j0.done;  assign o_done[1] = j1.done;
    assign o_win[0]  = j0.win;   assign o_win[1]  = j1.win;
    assign o_sym[0]  = j0.winner_symbol; assign o_sym[1] = j1.winner_symbol;
    assign o_line[0] = j0.win_line;      assign o_line[1] = j1.win_line;
    assign o_multi[0] = j0.multi_win;    assign o_multi[1] = j1.multi_win;
    assign o_draw[0] = j0.draw;  assign o_draw[1] = j1.draw;

    typedef struct packed {
        logic       win;
        logic       sym;
        logic [2:0] line;
        logic       multi;
        logic       draw;
        int         lat;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int e0;
    int dn[2], d0[2], dcyc[2];

    // Game rules: list every completed line, then derive the verdict and latency.
    function automatic res_t judge(logic [8:0] v, logic [8:0] s, bit all);
        int   L[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        int   hits[$];
        res_t r;
        r = '0;
        for (int k = 0; k < 8; k++)
            if (v[L[k][0]] && v[L[k][1]] && v[L[k][2]] &&
                s[L[k][0]] == s[L[k][1]] && s[L[k][1]] == s[L[k][2]])
                hits.push_back(k);
        if (hits.size() > 0) begin
            r.win   = 1'b1;
            r.line  = 3'(hits[0]);
            r.sym   = s[L[hits[0]][0]];
            r.multi = all && (hits.size() > 1);
            r.lat   = all ? 9 : hits[0] + 2;
        end else begin
            r.draw = (v == 9'h1FF);
            r.lat  = 9;
        end
        return r;
    endfunction

    task automatic chk(string nm, int p, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[scan_all=%0d] got %0d expected %0d at cycle %0d", nm, p, act, exp, cyc);
        end
    endtask

    // Cycle-level model: idle/busy with a countdown to the done edge.
    logic m_busy[2], m_done[2];
    int   m_cnt[2];
    res_t pend[2], mres[2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        for (int p = 0; p < 2; p++) begin
            if (!reset_n) begin
                m_busy[p] <= 1'b0;
                m_done[p] <= 1'b0;
                m_cnt[p]  <= 0;
                pend[p]   <= '0;
                mres[p]   <= '0;
            end else begin
                m_done[p] <= 1'b0;
                if (m_busy[p]) begin
                    if (m_cnt[p] == 1) begin
                        m_busy[p] <= 1'b0;
                        m_done[p] <= 1'b1;
                        mres[p]   <= pend[p];
                    end
                    m_cnt[p] <= m_cnt[p] - 1;
                end else if (start) begin
                    pend[p]   <= judge(cv, cs, p == 1);
                    m_cnt[p]  <= judge(cv, cs, p == 1).lat;
                    m_busy[p] <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus done bookkeeping.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            chk("busy",  p, o_busy[p],  m_busy[p]);
            chk("done",  p, o_done[p],  m_done[p]);
            chk("win",   p, o_win[p],   mres[p].win);
            chk("sym",   p, o_sym[p],   mres[p].sym);
            chk("line",  p, o_line[p],  mres[p].line);
            chk("multi", p, o_multi[p], mres[p].multi);
            chk("draw",  p, o_draw[p],  mres[p].draw);
            if (o_done[p]) begin
                dn[p]++;
                dcyc[p] = cyc;
            end
        end
    end

    task automatic run_eval(logic [8:0] v, logic [8:0] s);
        @(negedge clk);
        cv = v; cs = s; start = 1'b1;
        @(negedge clk);
        e0 = cyc; start = 1'b0;
        d0[0] = dn[0]; d0[1] = dn[1];
        repeat (11) @(negedge clk);
    endtask

    task automatic expect_res(int p, int w, int sy, int ln, int mu, int dr, int lat);
        chk("x_win",   p, o_win[p],   w);
        chk("x_sym",   p, o_sym[p],   sy);
        chk("x_line",  p, o_line[p],  ln);
        chk("x_multi", p, o_multi[p], mu);
        chk("x_draw",  p, o_draw[p],  dr);
        chk("x_ndone", p, dn[p] - d0[p], 1);
        chk("x_lat",   p, dcyc[p] - e0, lat);
    endtask

    task automatic expect_zero(int p);
        chk("z_busy", p, o_busy[p], 0);
        chk("z_done", p, o_done[p], 0);
        chk("z_win",  p, o_win[p],  0);
        chk("z_sym",  p, o_sym[p],  0);
        chk("z_line", p, o_line[p], 0);
        chk("z_multi", p, o_multi[p], 0);
        chk("z_draw", p, o_draw[p], 0);
    endtask

    initial begin
        res_t r;
        reset_n = 1'b0; start = 1'b0; cv = '0; cs = '0;
        dn = '{0, 0}; d0 = '{0, 0}; dcyc = '{0, 0};

        // Pin the model with hand-worked boards.
        r = judge(9'h054, 9'h054, 1'b1);
        chk("m_diag_line", 1, r.line, 7); chk("m_diag_sym", 1, r.sym, 1);
        r = judge(9'h1FF, 9'b011_110_001, 1'b1);
        chk("m_full_win", 1, r.win, 0);   chk("m_full_draw", 1, r.draw, 1);
        r = judge(9'h03F, 9'h000, 1'b1);
        chk("m_rows_multi", 1, r.multi, 1); chk("m_rows_line", 1, r.line, 0);
        r = judge(9'h03F, 9'h000, 1'b0);
        chk("m_rows_lat", 0, r.lat, 2);   chk("m_rows_multi0", 0, r.multi, 0);

        // Reset state.
        @(negedge clk);
        for (int p = 0; p < 2; p++) expect_zero(p);
        @(negedge clk);
        reset_n = 1'b1;

        // Empty board.
        run_eval(9'h000, 9'h000);
        for (int p = 0; p < 2; p++) expect_res(p, 0, 0, 0, 0, 0, 9);

        // Anti-diagonal 2,4,6 of symbol 1: last line, so no early exit.
        run_eval(9'h054, 9'h054);
        for (int p = 0; p < 2; p++) expect_res(p, 1, 1, 7, 0, 0, 9);

        // Full board, no line: draw.
        run_eval(9'h1FF, 9'b011_110_001);
        for (int p = 0; p < 2; p++) expect_res(p, 0, 0, 0, 0, 1, 9);

        // Illegal board, rows 0 and 1 of symbol 0.
        run_eval(9'h03F, 9'h000);
        expect_res(1, 1, 0, 0, 1, 0, 9);
        expect_res(0, 1, 0, 0, 0, 0, 2);

        // Start held high: re-accepted in the done cycle, back-to-back every 10.
        @(negedge clk);
        cv = 9'h003; cs = 9'h000; start = 1'b1;
        d0[0] = dn[0]; d0[1] = dn[1];
        repeat (20) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        for (int p = 0; p < 2; p++) chk("b2b_ndone", p, dn[p] - d0[p], 2);

        // Snapshot isolation: column 0 of symbol 1, board cleared, extra start.
        @(negedge clk);
        cv = 9'h049; cs = 9'h049; start = 1'b1;
        @(negedge clk);
        e0 = cyc; start = 1'b0; cv = 9'h000;
        d0[0] = dn[0]; d0[1] = dn[1];
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        expect_res(1, 1, 1, 3, 0, 0, 9);
        expect_res(0, 1, 1, 3, 0, 0, 5);

        // Reset at E4 mid-scan: outputs clear at once, no done follows.
        @(negedge clk);
        cv = 9'h003; cs = 9'h000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0[0] = dn[0]; d0[1] = dn[1];
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) expect_zero(p);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int p = 0; p < 2; p++) chk("rst_nodone", p, dn[p] - d0[p], 0);

        // Normal evaluation after reset: column 1 of symbol 0.
        run_eval(9'h092, 9'h000);
        expect_res(1, 1, 0, 4, 0, 0, 9);
        expect_res(0, 1, 0, 4, 0, 0, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
